// File: rtl/game_sequencer_if.sv
// game_sequencer_if
//   Bundles the button inputs, the cursor feedback and the round-status outputs
//   that pass between the game round controller and the rest of the system.
//   master : board/display side. Drives start, confirm and match, and observes the status.
//   slave  : game_sequencer. Observes the buttons and the cursor, and drives the status.
//   Signals:
//     start, confirm : debounced buttons (level)
//     match[2:0]     : cursor square reported by the active step block (0..3)
//     step[2:0]      : current level (0 = idle)
//     variety[2:0]   : target square (0..3)
//     score[7:0]     : total hits, saturating
//     lives[1:0]     : remaining lives
//     hit_pulse, miss_pulse : one-cycle judgement strobes
//     game_over, win : end-of-game status flags
interface game_sequencer_if;
  logic       start;
  logic       confirm;
  logic [2:0] match;
  logic [2:0] step;
  logic [2:0] variety;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;
  logic       win;

  modport master (
    output start, confirm, match,
    input  step, variety, score, lives, hit_pulse, miss_pulse, game_over, win
  );

  modport slave (
    input  start, confirm, match,
    output step, variety, score, lives, hit_pulse, miss_pulse, game_over, win
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
//   Round controller for the 4-square colour matching game. It picks a target
//   square for each round, judges confirm presses and round timeouts, and keeps
//   score, lives, level progress and the win/game-over status.
//   Ports:
//     clk25MHz : system clock
//     rst      : synchronous reset, active-high
//     bus      : game_sequencer_if.slave. Provides the button and cursor inputs
//                and carries all registered status outputs.
module game_sequencer #(
  parameter int unsigned ROUND_CYCLES  = 25_000_000,
  parameter int unsigned HITS_PER_STEP = 4,
  parameter int unsigned MAX_STEP      = 5,
  parameter int unsigned START_LIVES   = 3
) (
  input  logic              clk25MHz,
  input  logic              rst,
  game_sequencer_if.slave   bus
);

  localparam int unsigned TW = $clog2(ROUND_CYCLES + 1);
  localparam int unsigned HW = $clog2(HITS_PER_STEP + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ROUND_CYCLES - 1);
  localparam logic [HW-1:0] HITS_GOAL  = HW'(HITS_PER_STEP);
  localparam logic [2:0]    LAST_STEP  = 3'(MAX_STEP);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_HIT  = 3'd3,
    S_MISS = 3'd4,
    S_WIN  = 3'd5,
    S_OVER = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [2:0]    variety_q, variety_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          start_prev_q, confirm_prev_q;
  logic          hit_pulse_q, hit_pulse_d;
  logic          miss_pulse_q, miss_pulse_d;
  logic          game_over_q, game_over_d;
  logic          win_q, win_d;
  logic          start_rise, confirm_rise;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Target choice: the random candidate moves one square on if it equals the cursor,
  // so a fresh target can never already be matched
  function automatic logic [2:0] pick_target(input logic [1:0] rnd, input logic [2:0] cursor);
    logic [2:0] cand;
    cand = {1'b0, rnd};
    if (cand == cursor) begin
      return {1'b0, rnd + 2'd1};
    end else begin
      return cand;
    end
  endfunction

  assign start_rise   = bus.start & ~start_prev_q;
  assign confirm_rise = bus.confirm & ~confirm_prev_q;

  // Next-state and next-output logic of the round FSM
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    variety_d    = variety_q;
    score_d      = score_q;
    lives_d      = lives_q;
    hit_cnt_d    = hit_cnt_q;
    timer_d      = timer_q;
    lfsr_d       = lfsr_next(lfsr_q);
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        variety_d = pick_target(lfsr_q[1:0], bus.match);
        timer_d   = TIMER_LOAD;
        if (step_q == 3'd0) begin
          step_d = 3'd1;
        end else begin
          step_d = step_q;
        end
        state_d = S_PLAY;
      end

      S_PLAY: begin
        if (timer_q != {TW{1'b0}}) begin
          timer_d = timer_q - TW'(1);
        end else begin
          timer_d = timer_q;
        end
        // A confirm press takes priority over a timeout that expires in the same cycle
        if (confirm_rise) begin
          if (bus.match == variety_q) begin
            state_d = S_HIT;
          end else begin
            state_d = S_MISS;
          end
        end else if (timer_q == {TW{1'b0}}) begin
          state_d = S_MISS;
        end else begin
          state_d = S_PLAY;
        end
      end

      S_HIT: begin
        hit_pulse_d = 1'b1;
        if (score_q != 8'd255) begin
          score_d = score_q + 8'd1;
        end else begin
          score_d = score_q;
        end
        if (hit_cnt_q + HW'(1) == HITS_GOAL) begin
          hit_cnt_d = {HW{1'b0}};
          if (step_q == LAST_STEP) begin
            state_d = S_WIN;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_LOAD;
          end
        end else begin
          hit_cnt_d = hit_cnt_q + HW'(1);
          state_d   = S_LOAD;
        end
      end

      S_MISS: begin
        miss_pulse_d = 1'b1;
        if (lives_q <= 2'd1) begin
          lives_d = 2'd0;
          state_d = S_OVER;
        end else begin
          lives_d = lives_q - 2'd1;
          state_d = S_LOAD;
        end
      end

      S_WIN, S_OVER: begin
        if (start_rise) begin
          score_d   = 8'd0;
          lives_d   = LIVES_INIT;
          hit_cnt_d = {HW{1'b0}};
          step_d    = 3'd0;
          state_d   = S_LOAD;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered alongside the state so they track it exactly
    win_d       = (state_d == S_WIN);
    game_over_d = (state_d == S_OVER);
  end

  // State, datapath and output registers
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      state_q        <= S_IDLE;
      step_q         <= 3'd0;
      variety_q      <= 3'd0;
      score_q        <= 8'd0;
      lives_q        <= LIVES_INIT;
      hit_cnt_q      <= {HW{1'b0}};
      timer_q        <= {TW{1'b0}};
      lfsr_q         <= 8'hA5;
      start_prev_q   <= 1'b0;
      confirm_prev_q <= 1'b0;
      hit_pulse_q    <= 1'b0;
      miss_pulse_q   <= 1'b0;
      game_over_q    <= 1'b0;
      win_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      variety_q      <= variety_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      hit_cnt_q      <= hit_cnt_d;
      timer_q        <= timer_d;
      lfsr_q         <= lfsr_d;
      start_prev_q   <= bus.start;
      confirm_prev_q <= bus.confirm;
      hit_pulse_q    <= hit_pulse_d;
      miss_pulse_q   <= miss_pulse_d;
      game_over_q    <= game_over_d;
      win_q          <= win_d;
    end
  end

  assign bus.step       = step_q;
  assign bus.variety    = variety_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.miss_pulse = miss_pulse_q;
  assign bus.game_over  = game_over_q;
  assign bus.win        = win_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m;
  logic [7:0] m_prev;
  logic [2:0] exp_var;
  int exp_score, exp_lives, exp_step, exp_hits;

  game_sequencer_if bus ();

  game_sequencer #(
    .ROUND_CYCLES (16),
    .HITS_PER_STEP(2),
    .MAX_STEP     (3),
    .START_LIVES  (3)
  ) dut (
    .clk25MHz(clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value present just before the latest edge
  always @(posedge clk) begin
    m_prev <= m;
    if (rst) m <= 8'hA5;
    else     m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called right after a LOAD edge: predict the target from the reference LFSR
  task automatic load_check(input string tag);
    logic [2:0] cand;
    cand = {1'b0, m_prev[1:0]};
    if (cand == bus.match) exp_var = (cand + 3'd1) & 3'd3;
    else                   exp_var = cand;
    chk({tag, "_variety"}, 32'(bus.variety), 32'(exp_var));
    chk({tag, "_neq_match"}, 32'(bus.variety != bus.match), 32'd1);
  endtask

  task automatic do_hit(input string tag);
    bus.match   = exp_var;
    bus.confirm = 1'b1;
    tick();
    chk({tag, "_pulse_early"}, 32'(bus.hit_pulse), 32'd0);
    tick();
    exp_score++;
    exp_hits++;
    if (exp_hits == 2) begin
      exp_hits = 0;
      if (exp_step != 3) exp_step++;
    end
    chk({tag, "_hit_pulse"}, 32'(bus.hit_pulse), 32'd1);
    chk({tag, "_score"}, 32'(bus.score), 32'(exp_score));
    chk({tag, "_step"}, 32'(bus.step), 32'(exp_step));
    bus.confirm = 1'b0;
    if (bus.win !== 1'b1) begin
      tick();
      chk({tag, "_pulse_off"}, 32'(bus.hit_pulse), 32'd0);
      load_check(tag);
    end
  endtask

  task automatic do_miss(input string tag);
    bus.match   = (exp_var + 3'd1) & 3'd3;
    bus.confirm = 1'b1;
    tick();
    tick();
    exp_lives--;
    chk({tag, "_miss_pulse"}, 32'(bus.miss_pulse), 32'd1);
    chk({tag, "_lives"}, 32'(bus.lives), 32'(exp_lives));
    bus.confirm = 1'b0;
    tick();
    if (exp_lives == 0) chk({tag, "_game_over"}, 32'(bus.game_over), 32'd1);
    else                load_check(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_step"}, 32'(bus.step), 32'd0);
    chk({tag, "_variety"}, 32'(bus.variety), 32'd0);
    chk({tag, "_score"}, 32'(bus.score), 32'd0);
    chk({tag, "_lives"}, 32'(bus.lives), 32'd3);
    chk({tag, "_hit"}, 32'(bus.hit_pulse), 32'd0);
    chk({tag, "_miss"}, 32'(bus.miss_pulse), 32'd0);
    chk({tag, "_over"}, 32'(bus.game_over), 32'd0);
    chk({tag, "_win"}, 32'(bus.win), 32'd0);
  endtask

  // Start press from IDLE/WIN/GAME_OVER through the LOAD cycle
  task automatic start_game(input string tag);
    bus.start = 1'b1;
    tick();
    chk({tag, "_step_pre"}, 32'(bus.step), 32'd0);
    chk({tag, "_score_pre"}, 32'(bus.score), 32'd0);
    chk({tag, "_lives_pre"}, 32'(bus.lives), 32'd3);
    tick();
    bus.start = 1'b0;
    exp_step = 1; exp_score = 0; exp_lives = 3; exp_hits = 0;
    chk({tag, "_step"}, 32'(bus.step), 32'd1);
    chk({tag, "_over"}, 32'(bus.game_over), 32'd0);
    chk({tag, "_win"}, 32'(bus.win), 32'd0);
    load_check(tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.confirm = 1'b0;
    bus.match = 3'd2;
    exp_var = 3'd0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_values("rst0");

    // 1: start, first target
    start_game("start1");

    // 2: two hits advance to step 2
    do_hit("hit1");
    do_hit("hit2");

    // 3: timeout after 16 PLAY cycles
    repeat (15) tick();
    chk("to_wait_miss", 32'(bus.miss_pulse), 32'd0);
    chk("to_wait_lives", 32'(bus.lives), 32'd3);
    tick();
    chk("to_state_miss", 32'(bus.miss_pulse), 32'd0);
    tick();
    exp_lives = 2;
    chk("to_miss_pulse", 32'(bus.miss_pulse), 32'd1);
    chk("to_lives", 32'(bus.lives), 32'd2);
    tick();
    chk("to_pulse_off", 32'(bus.miss_pulse), 32'd0);
    load_check("to_load");

    // 3b: held confirm gives exactly one event
    bus.match = exp_var;
    bus.confirm = 1'b1;
    tick();
    tick();
    exp_score++;
    exp_hits++;
    chk("hold_score", 32'(bus.score), 32'(exp_score));
    tick();
    load_check("hold_load");
    repeat (5) tick();
    chk("hold_score_still", 32'(bus.score), 32'd3);
    chk("hold_no_pulse", 32'(bus.hit_pulse), 32'd0);
    bus.confirm = 1'b0;
    tick();

    // 4: wrong confirms down to game over
    do_miss("wrong1");
    do_miss("wrong2");
    bus.confirm = 1'b1;
    repeat (2) tick();
    bus.confirm = 1'b0;
    repeat (2) tick();
    chk("go_ignore_lives", 32'(bus.lives), 32'd0);
    chk("go_ignore_score", 32'(bus.score), 32'd3);
    chk("go_ignore_over", 32'(bus.game_over), 32'd1);
    start_game("restart_go");

    // 5: six hits to WIN
    for (int i = 0; i < 6; i++) do_hit("win_run");
    chk("win_flag", 32'(bus.win), 32'd1);
    bus.confirm = 1'b1;
    repeat (2) tick();
    bus.confirm = 1'b0;
    repeat (2) tick();
    chk("win_step_hold", 32'(bus.step), 32'd3);
    chk("win_score_hold", 32'(bus.score), 32'd6);
    chk("win_flag_hold", 32'(bus.win), 32'd1);
    chk("win_no_pulse", 32'(bus.hit_pulse), 32'd0);

    // 6: reset mid-PLAY with score 3
    start_game("restart_win");
    for (int i = 0; i < 3; i++) do_hit("pre_rst");
    chk("pre_rst_score", 32'(bus.score), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_mid");

    // 6b: confirm on the timer==0 cycle decides the round
    start_game("start_edge");
    repeat (15) tick();
    bus.match = exp_var;
    bus.confirm = 1'b1;
    tick();
    tick();
    chk("edge_hit", 32'(bus.hit_pulse), 32'd1);
    chk("edge_no_miss", 32'(bus.miss_pulse), 32'd0);
    chk("edge_score", 32'(bus.score), 32'd1);
    chk("edge_lives", 32'(bus.lives), 32'd3);
    bus.confirm = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
